hilo_div_sequencer: RTL

Multi-cycle controller for the DIV/DIVU path and the HI/LO register pair. It captures operands when the decoder issues a divide and runs a radix-2 restoring divide, one quotient bit per cycle. It writes the quotient to LO and the remainder to HI. It stalls the front end when MFHI/MFLO or a second divide issues while a divide is in flight. It sits beside the ALU in EX, and its stall output feeds the pipeline hazard/stall logic.

---
 rtl/hilo_div_if.sv | 29 ++
 rtl/hilo_div_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/hilo_div_if.sv
// Issue/result bundle between the EX-stage decoder, the hazard logic and the
// HI/LO divide sequencer.
interface hilo_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             rd_hi;
  logic             rd_lo;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_op, dividend, divisor, rd_hi, rd_lo, flush,
    input  stall, busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, signed_op, dividend, divisor, rd_hi, rd_lo, flush,
    output stall, busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/hilo_div_sequencer.sv
// DIV/DIVU sequencer: radix-2 restoring divide, one quotient bit per cycle,
// quotient to LO and remainder to HI; stalls HI/LO readers while in flight.
module hilo_div_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input logic        clk,
  input logic        rst_n,
  hilo_div_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             busy;

  // Trial subtract on the WIDTH+1 bit shifted remainder; when it succeeds the
  // difference is below the divisor, so the low WIDTH bits hold it exactly.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, b_q});
  assign diff   = rem_sh[WIDTH-1:0] - b_q;

  assign a_abs = (signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_abs = (signed_q && b_q[WIDTH-1]) ? -b_q : b_q;

  assign busy = (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          a_d      = bus.dividend;
          b_d      = bus.divisor;
          signed_d = bus.signed_op;
          q_neg_d  = bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          r_neg_d  = bus.signed_op & bus.dividend[WIDTH-1];
          state_d  = StPrep;
        end
      end
      StPrep: begin
        if (b_q == '0) begin
          lo_d    = '1;
          hi_d    = a_q;
          dbz_d   = 1'b1;
          state_d = StDone;
        end else begin
          quo_d   = a_abs;
          b_d     = b_abs;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = StIter;
        end
      end
      StIter: begin
        rem_d = ge ? diff : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        lo_d    = q_neg_q ? -quo_q : quo_q;
        hi_d    = r_neg_q ? -rem_q : rem_q;
        dbz_d   = 1'b0;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    // Flush abandons the divide without touching the architectural HI/LO.
    if (bus.flush) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = busy;
  assign bus.stall       = busy & (bus.rd_hi | bus.rd_lo | bus.start);
  assign bus.done        = (state_q == StDone);
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
